// File: rtl/ssd_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// scan FSM states, hex-to-segment table and decode helper.
package ssd_pkg;

    typedef enum logic [0:0] {
        StBlank,
        StDrive
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hexdec(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-high segment pattern.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hexdec(nibble_i);
    end

endmodule

// File: rtl/ssd_mux_scan.sv
// Multiplexed seven-segment scan driver: frame-synchronous display latch, per-slot
// dead time, optional leading-zero blanking and configurable pin polarity.
module ssd_mux_scan
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned REFRESH_DIV    = 1024,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lzb_en,
    output logic [6:0]              ssd_anode,
    output logic [NUM_DIGITS-1:0]   ssd_digit,
    output logic                    frame_start
);

    localparam int unsigned TickW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TickW-1:0]      TickLast    = TickW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]       IdxLast     = IdxW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DigOne      = NUM_DIGITS'(1);
    localparam logic [6:0]            SegInactive = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DigInactive = DIG_ACTIVE_LOW ? '1 : '0;
    localparam scan_state_e           StateRst    = (BLANK_CYCLES > 0) ? StBlank : StDrive;

    if (NUM_DIGITS < 1) begin : g_chk_digits
        $error("ssd_mux_scan: NUM_DIGITS must be >= 1");
    end
    if (REFRESH_DIV < 2) begin : g_chk_div
        $error("ssd_mux_scan: REFRESH_DIV must be >= 2");
    end
    if (BLANK_CYCLES >= REFRESH_DIV) begin : g_chk_blank
        $error("ssd_mux_scan: BLANK_CYCLES must be < REFRESH_DIV");
    end

    logic [TickW-1:0]        tick_q, tick_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    scan_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    lzb_q, lzb_d;
    logic [6:0]              anode_q, anode_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic                    frame_start_q, frame_start_d;

    logic                    tick_wrap, idx_last;
    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic [3:0]              cur_nibble;
    logic                    cur_lzb;
    logic [6:0]              cur_seg, seg_raw;
    logic [NUM_DIGITS-1:0]   dig_raw;

    // Counters and data registers; disp only changes on the frame boundary.
    always_comb begin
        tick_wrap = (tick_q == TickLast);
        idx_last  = (idx_q == IdxLast);
        tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
        idx_d     = idx_q;
        if (tick_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        pending_d = load ? value_in : pending_q;
        disp_d    = (tick_wrap && idx_last) ? pending_q : disp_q;
        lzb_d     = tick_wrap ? lzb_en : lzb_q;
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
        always_comb begin
            state_d = StDrive;
        end
    end else begin : g_blank
        localparam logic [TickW-1:0] BlankEnd = TickW'(BLANK_CYCLES);
        always_comb begin
            state_d = StDrive;
            if (tick_d < BlankEnd) begin
                state_d = StBlank;
            end
        end
    end

    // Digit k is suppressed when it and every more-significant nibble is zero.
    always_comb begin
        lzb_mask = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            lzb_mask[k] = lzb_q && ((disp_q >> (4 * k)) == '0);
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_lzb    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_nibble = disp_q[4*k +: 4];
                cur_lzb    = lzb_mask[k];
            end
        end
    end

    ssd_hex_decode u_hex_decode (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    always_comb begin
        seg_raw = SEG_OFF;
        dig_raw = '0;
        if (state_q == StDrive) begin
            dig_raw = DigOne << idx_q;
            seg_raw = cur_lzb ? SEG_OFF : cur_seg;
        end
        anode_d       = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        digit_d       = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
        frame_start_d = (tick_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_q        <= '0;
            idx_q         <= '0;
            state_q       <= StateRst;
            pending_q     <= '0;
            disp_q        <= '0;
            lzb_q         <= 1'b0;
            anode_q       <= SegInactive;
            digit_q       <= DigInactive;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            pending_q     <= pending_d;
            disp_q        <= disp_d;
            lzb_q         <= lzb_d;
            anode_q       <= anode_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ssd_anode   = anode_q;
    assign ssd_digit   = digit_q;
    assign frame_start = frame_start_q;

endmodule
